// File: rtl/gb_timer_if.sv
// rtl/gb_timer_if.sv - CPU bus and interrupt signals of the gb_timer block
interface gb_timer_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_wren;
  logic [7:0]  data_out;
  logic        sel;
  logic        timer_int;

  modport master (
    output cpu_addr, cpu_data_in, cpu_wren,
    input  data_out, sel, timer_int
  );

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_wren,
    output data_out, sel, timer_int
  );
endinterface

// File: rtl/gb_timer.sv
// rtl/gb_timer.sv - DIV/TIMA/TMA/TAC timer with delayed TMA reload and interrupt pulse
module gb_timer #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF04,
  parameter int          RELOAD_DELAY = 4
) (
  input  logic      clock,
  input  logic      reset,
  gb_timer_if.slave bus
);
  typedef enum logic {IDLE, RELOAD} state_t;

  localparam logic [2:0] RELOAD_INIT = 3'(RELOAD_DELAY - 1);

  state_t      state;
  logic [15:0] div_cnt;
  logic [15:0] div_next;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [7:0]  tma_next;
  logic [2:0]  tac;
  logic [2:0]  tac_next;
  logic [2:0]  reload_cnt;
  logic        in_prev;
  logic        in_next;
  logic        tbit_next;
  logic        fall;
  logic        timer_int_q;
  logic [15:0] offset;
  logic        wr_div;
  logic        wr_tima;
  logic        wr_tma;
  logic        wr_tac;

  assign offset  = bus.cpu_addr - BASE_ADDR;
  assign bus.sel = (offset[15:2] == 14'd0);
  assign wr_div  = bus.cpu_wren & bus.sel & (offset[1:0] == 2'd0);
  assign wr_tima = bus.cpu_wren & bus.sel & (offset[1:0] == 2'd1);
  assign wr_tma  = bus.cpu_wren & bus.sel & (offset[1:0] == 2'd2);
  assign wr_tac  = bus.cpu_wren & bus.sel & (offset[1:0] == 2'd3);

  assign div_next = wr_div ? 16'd0 : div_cnt + 16'd1;
  assign tac_next = wr_tac ? bus.cpu_data_in[2:0] : tac;
  assign tma_next = wr_tma ? bus.cpu_data_in : tma;

  // Edge detect on post-edge values, so DIV/TAC write glitches count on the write edge itself
  always_comb begin
    tbit_next = 1'b0;
    case (tac_next[1:0])
      2'd0:    tbit_next = div_next[9];
      2'd1:    tbit_next = div_next[3];
      2'd2:    tbit_next = div_next[5];
      default: tbit_next = div_next[7];
    endcase
  end

  assign in_next = tac_next[2] & tbit_next;
  assign fall    = in_prev & ~in_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      div_cnt     <= 16'd0;
      tima        <= 8'd0;
      tma         <= 8'd0;
      tac         <= 3'd0;
      reload_cnt  <= 3'd0;
      in_prev     <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      tac         <= tac_next;
      tma         <= tma_next;
      in_prev     <= in_next;
      timer_int_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_tima) begin
            tima <= bus.cpu_data_in;
          end else if (fall) begin
            if (tima == 8'hFF) begin
              tima       <= 8'd0;
              reload_cnt <= RELOAD_INIT;
              state      <= RELOAD;
            end else begin
              tima <= tima + 8'd1;
            end
          end
        end
        RELOAD: begin
          if (wr_tima) begin
            tima  <= bus.cpu_data_in;
            state <= IDLE;
          end else if (reload_cnt == 3'd0) begin
            tima        <= tma_next;
            timer_int_q <= 1'b1;
            state       <= IDLE;
          end else begin
            reload_cnt <= reload_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.timer_int = timer_int_q;

  always_comb begin
    bus.data_out = 8'hFF;
    if (bus.sel) begin
      case (offset[1:0])
        2'd0:    bus.data_out = div_cnt[15:8];
        2'd1:    bus.data_out = tima;
        2'd2:    bus.data_out = tma;
        default: bus.data_out = {5'b11111, tac};
      endcase
    end
  end
endmodule

// File: tb/tb_gb_timer.sv
// tb/tb_gb_timer.sv - directed and random checks of gb_timer against a behavioural model
module tb_gb_timer;
  localparam logic [15:0] BASE = 16'hFF04;
  localparam int          RD   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gb_timer_if bus();

  gb_timer #(.BASE_ADDR(BASE), .RELOAD_DELAY(RD)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_div, m_tima, m_tma, m_tac, m_left;
  bit m_pend, m_int;

  function automatic bit in_sig(int d, int t);
    int b;
    case (t & 3)
      0:       b = 9;
      1:       b = 3;
      2:       b = 5;
      default: b = 7;
    endcase
    return ((t >> 2) & 1) != 0 && ((d >> b) & 1) != 0;
  endfunction

  function automatic int reg_off(logic [15:0] a);
    return int'(a) - int'(BASE);
  endfunction

  function automatic logic [7:0] m_read(logic [15:0] a);
    int off = reg_off(a);
    if (off < 0 || off > 3) return 8'hFF;
    case (off)
      0:       return 8'((m_div >> 8) & 255);
      1:       return 8'(m_tima);
      2:       return 8'(m_tma);
      default: return 8'(248 | m_tac);
    endcase
  endfunction

  task automatic model_reset();
    m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
    m_pend = 0; m_left = 0; m_int = 0;
  endtask

  task automatic model_edge(bit wr, logic [15:0] a, logic [7:0] d);
    int off = reg_off(a);
    bit hit = wr && off >= 0 && off < 4;
    int div_n, tac_n, tma_n;
    bit fall;
    div_n = (hit && off == 0) ? 0 : (m_div + 1) % 65536;
    tac_n = (hit && off == 3) ? (int'(d) & 7) : m_tac;
    tma_n = (hit && off == 2) ? int'(d) : m_tma;
    fall  = in_sig(m_div, m_tac) && !in_sig(div_n, tac_n);
    m_int = 0;
    if (m_pend) begin
      if (hit && off == 1) begin
        m_tima = int'(d);
        m_pend = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_tima = tma_n;
          m_int  = 1;
          m_pend = 0;
        end
      end
    end else if (hit && off == 1) begin
      m_tima = int'(d);
    end else if (fall) begin
      if (m_tima == 255) begin
        m_tima = 0;
        m_pend = 1;
        m_left = RD;
      end else begin
        m_tima++;
      end
    end
    m_div = div_n; m_tac = tac_n; m_tma = tma_n;
  endtask

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(bit wr, logic [15:0] a, logic [7:0] d);
    bus.cpu_wren    = wr;
    bus.cpu_addr    = a;
    bus.cpu_data_in = d;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(wr, a, d);
    @(negedge clk);
    check("timer_int", {15'd0, bus.timer_int}, {15'd0, m_int});
    bus.cpu_wren = 1'b0;
  endtask

  task automatic rd(string tag, logic [15:0] a);
    int off = reg_off(a);
    bus.cpu_wren = 1'b0;
    bus.cpu_addr = a;
    #1;
    check({tag, "_sel"}, {15'd0, bus.sel}, {15'd0, (off >= 0 && off < 4)});
    check({tag, "_data"}, {8'd0, bus.data_out}, {8'd0, m_read(a)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 16'h0000, 8'h00);
    cyc(0, 16'h0000, 8'h00);
    rst = 1'b0;
  endtask

  task automatic setup_overflow();
    do_reset();
    cyc(1, BASE + 16'd3, 8'h05);
    cyc(1, BASE + 16'd1, 8'hFE);
    cyc(1, BASE + 16'd2, 8'hA0);
  endtask

  initial begin
    int zeros, ints, t;
    bit seen;
    logic [15:0] a;
    bus.cpu_addr = 16'h0000; bus.cpu_data_in = 8'h00; bus.cpu_wren = 1'b0;
    model_reset();

    // Reset state and free-running divider
    do_reset();
    rd("rst_div", BASE);
    check("rst_div_zero", {8'd0, bus.data_out}, 16'h0000);
    rd("rst_tima", BASE + 16'd1);
    rd("rst_tac", BASE + 16'd3);
    check("rst_tac_f8", {8'd0, bus.data_out}, 16'h00F8);
    ints = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(0, 16'h0000, 8'h00);
      ints += int'(bus.timer_int);
    end
    rd("div256", BASE);
    check("div256_01", {8'd0, bus.data_out}, 16'h0001);
    check("div256_no_int", 16'(ints), 16'd0);

    // Overflow, four clocks of 0x00, then TMA reload with a single pulse
    setup_overflow();
    zeros = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cyc(0, 16'h0000, 8'h00);
      seen = bus.timer_int;
      rd("ovf_tima", BASE + 16'd1);
      if (!seen && bus.data_out == 8'h00) zeros++;
    end
    check("ovf_int_seen", {15'd0, seen}, 16'd1);
    check("ovf_zero_clocks", 16'(zeros), 16'd4);
    check("ovf_reload_a0", {8'd0, bus.data_out}, 16'h00A0);
    cyc(0, 16'h0000, 8'h00);
    check("ovf_int_single", {15'd0, bus.timer_int}, 16'd0);

    // TIMA write during reload cancels reload and interrupt
    setup_overflow();
    for (int i = 0; i < 100 && !m_pend; i++) cyc(0, 16'h0000, 8'h00);
    rd("cancel_ovf", BASE + 16'd1);
    check("cancel_ovf_zero", {8'd0, bus.data_out}, 16'h0000);
    cyc(0, 16'h0000, 8'h00);
    cyc(1, BASE + 16'd1, 8'h33);
    rd("cancel_tima", BASE + 16'd1);
    check("cancel_tima_33", {8'd0, bus.data_out}, 16'h0033);
    ints = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 16'h0000, 8'h00);
      ints += int'(bus.timer_int);
    end
    check("cancel_no_int", 16'(ints), 16'd0);

    // TMA write on the reload edge is what gets loaded
    setup_overflow();
    for (int i = 0; i < 100 && !m_pend; i++) cyc(0, 16'h0000, 8'h00);
    for (int i = 0; i < RD - 1; i++) cyc(0, 16'h0000, 8'h00);
    cyc(1, BASE + 16'd2, 8'h55);
    check("tma_edge_int", {15'd0, bus.timer_int}, 16'd1);
    rd("tma_edge", BASE + 16'd1);
    check("tma_edge_55", {8'd0, bus.data_out}, 16'h0055);
    cyc(0, 16'h0000, 8'h00);
    check("tma_edge_int_once", {15'd0, bus.timer_int}, 16'd0);

    // DIV write glitch: counts only when the selected bit was high
    do_reset();
    cyc(1, BASE + 16'd3, 8'h05);
    for (int i = 0; i < 64 && ((m_div >> 3) & 1) == 0; i++) cyc(0, 16'h0000, 8'h00);
    t = m_tima;
    cyc(1, BASE, 8'h5A);
    rd("divwr_div", BASE);
    check("divwr_div_00", {8'd0, bus.data_out}, 16'h0000);
    rd("divwr_tima", BASE + 16'd1);
    check("divwr_tima_inc", {8'd0, bus.data_out}, 16'((t + 1) & 255));
    cyc(0, 16'h0000, 8'h00);
    t = m_tima;
    cyc(1, BASE, 8'h00);
    rd("divwr_low", BASE + 16'd1);
    check("divwr_low_same", {8'd0, bus.data_out}, 16'(t));

    // TAC write glitch and unselected address
    do_reset();
    cyc(1, BASE + 16'd3, 8'h04);
    for (int i = 0; i < 2000 && ((m_div >> 9) & 1) == 0; i++) cyc(0, 16'h0000, 8'h00);
    t = m_tima;
    cyc(1, BASE + 16'd3, 8'h00);
    rd("tacwr_tima", BASE + 16'd1);
    check("tacwr_tima_inc", {8'd0, bus.data_out}, 16'((t + 1) & 255));
    rd("unsel", 16'hFF08);
    check("unsel_sel", {15'd0, bus.sel}, 16'd0);
    check("unsel_data", {8'd0, bus.data_out}, 16'h00FF);

    // Random bus traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      a = BASE - 16'd1 + 16'($urandom_range(0, 5));
      cyc($urandom_range(0, 99) < 8, a, 8'($urandom));
      a = BASE - 16'd1 + 16'($urandom_range(0, 5));
      rd("rand", a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gb_timer.md
Name: gb_timer

Overview:
- Game Boy DIV/TIMA/TMA/TAC timer block; peripheral on the CPU memory bus, decoded at 0xFF04–0xFF07.
- Consumes CPU bus writes and produces `timer_int` for the interrupt logic, replacing the currently undriven timer interrupt line.
- Its read data is muxed by the memory map into the CPU data path.
- Runs on the CPU clock: one internal divider tick per clock.

Parameters:
- BASE_ADDR, 16'hFF04, address of DIV; TIMA/TMA/TAC follow at +1/+2/+3.
- RELOAD_DELAY, 4, clocks between TIMA overflow and TMA reload / interrupt (range 1–7).

Ports:
- clock  in  1  CPU clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU bus address.
- cpu_data_in  in  8  CPU write data.
- cpu_wren  in  1  write strobe; a write occurs when high at a rising edge and cpu_addr hits a register.
- data_out  out  8  combinational read data for cpu_addr; 8'hFF when not selected.
- sel  out  1  combinational; high when cpu_addr is within BASE_ADDR..BASE_ADDR+3.
- timer_int  out  1  one-clock pulse requesting the timer interrupt.

Behaviour:
- Reset:
  - 16-bit divider `div_cnt`=0; TIMA=0, TMA=0, TAC=0; reload state idle; edge-detect register=0; timer_int=0.
  - Reset has priority over all writes and counting.
- Divider: `div_cnt` increments by 1 every clock and wraps 0xFFFF→0. DIV reads `div_cnt[15:8]`.
- DIV write (any data): `div_cnt` becomes 0 on that edge; no increment that cycle.
- Tick source: `tbit` = `div_cnt` bit selected by TAC[1:0] — 00→bit9, 01→bit3, 10→bit5, 11→bit7.
- TIMA increment: `in_sig` = TAC[2] & `tbit`. TIMA increments on a 1→0 transition of `in_sig` (registered previous value vs current).
  - Glitches count: a DIV write or TAC write that drops `in_sig` from 1 to 0 increments TIMA.
- Reads:
  - DIV, TIMA and TMA read as stored.
  - TAC reads {5'b11111, TAC[2:0]}.
  - data_out reflects register values before the current edge; no read latency.
- Overflow state machine, states IDLE and RELOAD:
  - IDLE→RELOAD when an increment occurs with TIMA==0xFF. TIMA becomes 0x00 and an internal counter is loaded with RELOAD_DELAY-1.
  - RELOAD:
    - TIMA reads 0x00.
    - The counter decrements each clock.
    - When the counter is 0: TIMA←TMA (the current TMA, including a TMA write on this same edge), timer_int=1 for exactly that one clock, then →IDLE.
  - Write to TIMA while in RELOAD: reload and interrupt are cancelled, TIMA takes the written value, →IDLE.
  - Increments are suppressed while in RELOAD.
- Ordinary TIMA write in IDLE: the written value wins over a coincident increment on the same edge.
- TMA write: takes effect the next cycle. If it coincides with the reload edge, the new value is loaded into TIMA.
- TAC write: only bits [2:0] are stored.
- Unselected addresses and writes are ignored. data_out=8'hFF and sel=0.
- timer_int is never asserted for two consecutive clocks.

Test Plan:
- Reset, then run 256 clocks → DIV reads 0x01, TIMA 0x00, TAC reads 0xF8, timer_int never asserted.
- Write TAC=0x05 (bit3, period 16), TIMA=0xFE, TMA=0xA0; run.
  - TIMA→0xFF after the next falling edge of bit3.
  - Next falling edge → TIMA=0x00 for 4 clocks, then TIMA=0xA0 with a single-clock timer_int.
- Same setup; write TIMA=0x33 two clocks after overflow → TIMA=0x33, no timer_int, no reload.
- Same setup; write TMA=0x55 on the reload edge → TIMA=0x55, timer_int pulses once.
- TAC=0x05; run until `div_cnt[3]`=1, then write DIV → TIMA increments by exactly 1 on that edge, DIV reads 0x00. Repeat with `div_cnt[3]`=0 → no increment.
- TAC=0x04 with bit9=1, then write TAC=0x00 → TIMA increments once. Read 0xFF08 → sel=0, data_out=0xFF.
